uart_cfg_rx: RTL and testbench

Configuration-port UART receiver for the eFPGA top level. It deserialises the 8N1 byte stream arriving on `Rx` and hunts for a sync word. After sync, it packs bytes MSB-first into 32-bit configuration words and presents each word with a one-cycle `WriteStrobe` to the frame/config write logic. It is the device-side counterpart of the bench task that drives `Rx` with `CLKS_PER_BIT` clocks per bit.

---
 rtl/uart_cfg_pkg.sv | 22 ++
 rtl/uart_cfg_rx_byte.sv | 113 +++++++++++
 rtl/uart_cfg_rx.sv | 140 ++++++++++++++
 tb/tb_uart_cfg_rx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_cfg_pkg.sv
// Shared types and constants for the configuration-port UART receiver.
package uart_cfg_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic {
    PK_HUNT   = 1'b0,
    PK_ACTIVE = 1'b1
  } pack_state_t;

  localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;

  function automatic logic [31:0] shift_in_byte(input logic [31:0] w, input logic [7:0] b);
    return {w[23:0], b};
  endfunction

endpackage

// File: rtl/uart_cfg_rx_byte.sv
// 8N1 byte receiver: input synchroniser plus start/data/stop sampling FSM.
module uart_byte_rx
  import uart_cfg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync1_r;
  logic             rx_s;
  rx_state_t        state_r, state_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic [2:0]       bit_r, bit_nxt;
  logic [7:0]       shift_r, shift_nxt;
  logic             valid_nxt, err_nxt;

  // Two-flop synchroniser; both stages idle high like the line
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_r <= rx;
      rx_s    <= sync1_r;
    end
  end

  // Next-state logic; stop is sampled mid-bit so zero-gap bytes still line up
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r + CNT_ONE;
    bit_nxt   = bit_r;
    shift_nxt = shift_r;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state_r)
      RX_IDLE: begin
        cnt_nxt = CNT_ZERO;
        bit_nxt = 3'd0;
        if (!rx_s) state_nxt = RX_START;
        else       state_nxt = RX_IDLE;
      end
      RX_START: begin
        if (cnt_r == HALF_M1) begin
          cnt_nxt = CNT_ZERO;
          if (rx_s) state_nxt = RX_IDLE;
          else      state_nxt = RX_DATA;
        end else begin
          state_nxt = RX_START;
        end
      end
      RX_DATA: begin
        if (cnt_r == FULL_M1) begin
          cnt_nxt   = CNT_ZERO;
          shift_nxt = {rx_s, shift_r[7:1]};
          bit_nxt   = bit_r + 3'd1;
          if (bit_r == 3'd7) state_nxt = RX_STOP;
          else               state_nxt = RX_DATA;
        end else begin
          state_nxt = RX_DATA;
        end
      end
      RX_STOP: begin
        if (cnt_r == FULL_M1) begin
          cnt_nxt   = CNT_ZERO;
          state_nxt = RX_IDLE;
          if (rx_s) valid_nxt = 1'b1;
          else      err_nxt   = 1'b1;
        end else begin
          state_nxt = RX_STOP;
        end
      end
      default: begin
        state_nxt = RX_IDLE;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // State, counters and registered pulses
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= RX_IDLE;
      cnt_r      <= CNT_ZERO;
      bit_r      <= 3'd0;
      shift_r    <= 8'd0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      cnt_r      <= cnt_nxt;
      bit_r      <= bit_nxt;
      shift_r    <= shift_nxt;
      byte_valid <= valid_nxt;
      frame_err  <= err_nxt;
    end
  end

  assign rx_byte = shift_r;

endmodule

// File: rtl/uart_cfg_rx.sv
// Config-port UART receiver: sync-word hunt, MSB-first word packing, idle timeout.
module uart_cfg_rx
  import uart_cfg_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 8,
  parameter logic [31:0] SYNC_WORD    = DEFAULT_SYNC_WORD,
  parameter int          TIMEOUT_BITS = 64
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic        Rx,
  output logic [31:0] WriteData,
  output logic        WriteStrobe,
  output logic        ComActive,
  output logic        ReceiveLED,
  output logic        FrameError
);

  localparam int LIMIT  = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int IDLE_W = $clog2(LIMIT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(LIMIT);
  localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);

  logic        byte_valid_s;
  logic [7:0]  rx_byte_s;
  logic        frame_err_s;

  pack_state_t       pk_state_r, pk_state_nxt;
  logic [31:0]       shreg_r, shreg_nxt, shreg_cand_s;
  logic [31:0]       word_r, word_nxt;
  logic [1:0]        bcnt_r, bcnt_nxt;
  logic [IDLE_W-1:0] idle_r, idle_nxt;
  logic              timeout_s;
  logic              strobe_nxt;
  logic [31:0]       wdata_nxt;
  logic              led_nxt;

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_rx (
    .clk       (CLK),
    .resetn    (resetn),
    .rx        (Rx),
    .byte_valid(byte_valid_s),
    .rx_byte   (rx_byte_s),
    .frame_err (frame_err_s)
  );

  assign FrameError = frame_err_s;

  // Saturating idle counter, cleared by every good byte
  always_comb begin
    idle_nxt  = idle_r;
    timeout_s = (idle_r == IDLE_LIMIT);
    if (byte_valid_s) begin
      idle_nxt = {IDLE_W{1'b0}};
    end else if (idle_r != IDLE_LIMIT) begin
      idle_nxt = idle_r + IDLE_ONE;
    end else begin
      idle_nxt = idle_r;
    end
  end

  // Packer: a byte arriving on the timeout cycle takes priority over the abort
  always_comb begin
    pk_state_nxt = pk_state_r;
    shreg_nxt    = shreg_r;
    word_nxt     = word_r;
    bcnt_nxt     = bcnt_r;
    strobe_nxt   = 1'b0;
    wdata_nxt    = WriteData;
    led_nxt      = ReceiveLED;
    shreg_cand_s = shift_in_byte(shreg_r, rx_byte_s);
    case (pk_state_r)
      PK_HUNT: begin
        if (byte_valid_s) begin
          shreg_nxt = shreg_cand_s;
          if (shreg_cand_s == SYNC_WORD) begin
            pk_state_nxt = PK_ACTIVE;
            bcnt_nxt     = 2'd0;
            word_nxt     = 32'd0;
          end else begin
            pk_state_nxt = PK_HUNT;
          end
        end else begin
          pk_state_nxt = PK_HUNT;
        end
      end
      PK_ACTIVE: begin
        if (byte_valid_s) begin
          word_nxt = shift_in_byte(word_r, rx_byte_s);
          bcnt_nxt = bcnt_r + 2'd1;
          if (bcnt_r == 2'd3) begin
            wdata_nxt  = word_nxt;
            strobe_nxt = 1'b1;
            led_nxt    = ~ReceiveLED;
          end else begin
            strobe_nxt = 1'b0;
          end
        end else if (frame_err_s || timeout_s) begin
          pk_state_nxt = PK_HUNT;
          shreg_nxt    = 32'd0;
          word_nxt     = 32'd0;
          bcnt_nxt     = 2'd0;
        end else begin
          pk_state_nxt = PK_ACTIVE;
        end
      end
      default: begin
        pk_state_nxt = PK_HUNT;
      end
    endcase
  end

  // Packer state and registered outputs
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      pk_state_r  <= PK_HUNT;
      shreg_r     <= 32'd0;
      word_r      <= 32'd0;
      bcnt_r      <= 2'd0;
      idle_r      <= {IDLE_W{1'b0}};
      WriteData   <= 32'd0;
      WriteStrobe <= 1'b0;
      ComActive   <= 1'b0;
      ReceiveLED  <= 1'b0;
    end else begin
      pk_state_r  <= pk_state_nxt;
      shreg_r     <= shreg_nxt;
      word_r      <= word_nxt;
      bcnt_r      <= bcnt_nxt;
      idle_r      <= idle_nxt;
      WriteData   <= wdata_nxt;
      WriteStrobe <= strobe_nxt;
      ComActive   <= (pk_state_nxt == PK_ACTIVE);
      ReceiveLED  <= led_nxt;
    end
  end

endmodule

// File: tb/tb_uart_cfg_rx.sv
// Scoreboard bench for uart_cfg_rx: directed byte streams, monitor checks strobes and frame errors.
module tb_uart_cfg_rx;

  localparam int CPB   = 8;
  localparam int LIMIT = 64 * CPB;

  logic        CLK = 1'b0;
  logic        resetn = 1'b0;
  logic        Rx = 1'b1;
  logic [31:0] WriteData;
  logic        WriteStrobe;
  logic        ComActive;
  logic        ReceiveLED;
  logic        FrameError;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          exp_fe = 0;
  logic        model_led = 1'b0;
  logic [31:0] exp_word;

  uart_cfg_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_WORD   (32'hFAB0_FAB1),
    .TIMEOUT_BITS(64)
  ) dut (
    .CLK        (CLK),
    .resetn     (resetn),
    .Rx         (Rx),
    .WriteData  (WriteData),
    .WriteStrobe(WriteStrobe),
    .ComActive  (ComActive),
    .ReceiveLED (ReceiveLED),
    .FrameError (FrameError)
  );

  always #5 CLK = ~CLK;

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    @(negedge CLK);
    Rx = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      repeat (CPB) @(negedge CLK);
    end
    Rx = stop_bit;
    repeat (CPB - 1) @(negedge CLK);
    Rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Monitor: every strobe must match the oldest queued word, every FrameError must be expected
  always @(negedge CLK) begin
    if (resetn) begin
      if (WriteStrobe) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_strobe: got %h expected no strobe", WriteData);
        end else begin
          exp_word = exp_q.pop_front();
          model_led = ~model_led;
          check_word("write_data", WriteData, exp_word);
          check_bit("receive_led", ReceiveLED, model_led);
        end
      end
      if (FrameError) begin
        n_vec++;
        if (exp_fe > 0) begin
          exp_fe--;
        end else begin
          n_err++;
          $display("FAIL unexpected_frame_error: got 1 expected 0");
        end
      end
    end
  end

  initial begin
    // Reset state
    resetn = 1'b0;
    idle(3);
    check_word("reset_write_data", WriteData, 32'h0000_0000);
    check_bit("reset_strobe", WriteStrobe, 1'b0);
    check_bit("reset_com_active", ComActive, 1'b0);
    check_bit("reset_led", ReceiveLED, 1'b0);
    check_bit("reset_frame_error", FrameError, 1'b0);
    resetn = 1'b1;
    idle(4);

    // Basic frame, then a repeated sync word carried as data
    send_word(32'hFAB0_FAB1);
    idle(4);
    check_bit("sync_com_active", ComActive, 1'b1);
    exp_q.push_back(32'h1234_5678);
    send_word(32'h1234_5678);
    idle(4);
    check_bit("basic_led", ReceiveLED, 1'b1);
    check_word("basic_hold", WriteData, 32'h1234_5678);
    exp_q.push_back(32'hFAB0_FAB1);
    send_word(32'hFAB0_FAB1);
    idle(4);
    check_bit("sync_as_data_active", ComActive, 1'b1);

    // Framing error aborts the frame; data without resync is ignored
    send_byte(8'h11);
    send_byte(8'h22);
    exp_fe++;
    send_byte(8'h33, 1'b0);
    idle(20 * CPB);
    check_bit("ferr_com_active", ComActive, 1'b0);
    send_word(32'h3344_5566);
    idle(4 * CPB);
    check_bit("ferr_no_resync", ComActive, 1'b0);

    // Pre-sync filtering
    send_byte(8'h00);
    send_byte(8'hFA);
    send_word(32'hFAB0_FAB1);
    idle(4);
    check_bit("presync_active", ComActive, 1'b1);
    exp_q.push_back(32'hAABB_CCDD);
    send_word(32'hAABB_CCDD);
    idle(4);

    // Timeout after a partial word
    send_byte(8'h01);
    send_byte(8'h02);
    idle(LIMIT - 8);
    check_bit("timeout_before", ComActive, 1'b1);
    idle(16);
    check_bit("timeout_after", ComActive, 1'b0);
    send_word(32'hFAB0_FAB1);
    exp_q.push_back(32'h0102_0304);
    send_word(32'h0102_0304);
    idle(4);

    // Glitch rejection: short low pulse must not disturb the stream
    @(negedge CLK);
    Rx = 1'b0;
    idle(3);
    Rx = 1'b1;
    idle(4 * CPB);
    check_bit("glitch_active", ComActive, 1'b1);
    exp_q.push_back(32'h5A5A_0F0F);
    send_word(32'h5A5A_0F0F);
    idle(4);

    // Reset during the data bits of the third byte
    send_byte(8'h01);
    send_byte(8'h02);
    fork
      send_byte(8'hFF);
      begin
        repeat (3 * CPB) @(negedge CLK);
        resetn = 1'b0;
        @(negedge CLK);
        resetn = 1'b1;
      end
    join
    model_led = 1'b0;
    idle(2 * CPB);
    check_word("rst_write_data", WriteData, 32'h0000_0000);
    check_bit("rst_com_active", ComActive, 1'b0);
    check_bit("rst_led", ReceiveLED, 1'b0);
    send_byte(8'h77);
    send_word(32'h1122_3344);
    idle(4 * CPB);
    check_bit("rst_no_sync", ComActive, 1'b0);

    // Everything queued must have been seen
    check_word("pending_words", 32'(exp_q.size()), 32'd0);
    check_word("pending_frame_errors", 32'(exp_fe), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
